// File: rtl/mvb_frame_seq_ctrl_pkg.sv
// mvb_pkg: shared types and constants for the MVB receive-path frame sequencer.
//   state_e    : sequencer states
//   ERR_*      : err_code values reported on frame_err (0 on success)
//   DEF_*      : default bit-time counts per frame field
//   max4()     : helper used to size the shared bit counter
package mvb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DELIM     = 3'd1,
        DATA      = 3'd2,
        CRC       = 3'd3,
        END_DELIM = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_DELIM   = 3'd1;
    localparam logic [2:0] ERR_LENGTH  = 3'd2;
    localparam logic [2:0] ERR_SIGNAL  = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_END     = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;

    localparam int DEF_WORD_BITS  = 16;
    localparam int DEF_CRC_BITS   = 8;
    localparam int DEF_DELIM_BITS = 9;
    localparam int DEF_END_BITS   = 3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/mvb_frame_seq_ctrl_bit_timer.sv
// mvb_bit_timer: bit-time counter and bit-gap watchdog shared by all states.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clr_i         : restart both counters (asserted on every state change)
//   bit_tick_i    : one strobe per received bit time
//   term_i        : bit times in the current field
//   done_o        : this bit_tick completes the field (counter wraps to 0)
//   timeout_o     : this is the TIMEOUT_CYC-th consecutive cycle without a bit_tick
module mvb_bit_timer #(
    parameter int CNT_W       = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             bit_tick_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o,
    output logic             timeout_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] bit_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;

    assign done_o    = bit_tick_i && (bit_cnt_q == term_i - 1'b1);
    assign timeout_o = !bit_tick_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            // wrap on field completion so back-to-back words need no state change
            if (bit_tick_i)
                bit_cnt_q <= done_o ? '0 : bit_cnt_q + 1'b1;
            if (bit_tick_i)
                to_cnt_q <= '0;
            else if (to_cnt_q != TO_W'(TIMEOUT_CYC))
                to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mvb_frame_seq_ctrl.sv
// mvb_frame_seq_ctrl: sequences one received MVB frame:
// start delimiter -> data words / CRC groups -> end delimiter -> done.
//   clk_24M, rst           : clock, synchronous active-high reset
//   bit_tick               : one strobe per received bit time
//   frame_start            : start bit seen (acted on only in IDLE)
//   s_frame/m_frame        : slave/master delimiter recognised
//   e_frame                : end delimiter recognised
//   delimiter_error        : delimiter mismatch
//   crc_error              : CRC result, valid the cycle after crc_read
//   signal_error/quality_error : line faults, abort immediately
//   frame_length           : slave frame length in words, sampled with s_frame
//   *_en, deser_wait, frame_end : level enables decoded from state
//   crc_read, frame_ok, frame_err : registered one-cycle pulses
//   err_code               : cause of the last rejection (0 after success)
//   word_count             : data words received in the current frame
module mvb_frame_seq_ctrl
    import mvb_pkg::*;
#(
    parameter int MAX_WORDS     = 16,
    parameter int LEN_W         = 5,
    parameter int WORD_BITS     = DEF_WORD_BITS,
    parameter int WORDS_PER_CRC = 4,
    parameter int CRC_BITS      = DEF_CRC_BITS,
    parameter int DELIM_BITS    = DEF_DELIM_BITS,
    parameter int END_BITS      = DEF_END_BITS,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic             clk_24M,
    input  logic             rst,
    input  logic             bit_tick,
    input  logic             frame_start,
    input  logic             s_frame,
    input  logic             m_frame,
    input  logic             e_frame,
    input  logic             delimiter_error,
    input  logic             crc_error,
    input  logic             signal_error,
    input  logic             quality_error,
    input  logic [LEN_W-1:0] frame_length,
    output logic             start_check_en,
    output logic             delimiter_check_en,
    output logic             deser_en,
    output logic             deser_wait,
    output logic             crc_check_en,
    output logic             crc_read,
    output logic             frame_end,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [LEN_W-1:0] word_count
);

    localparam int CNT_W = $clog2(max4(WORD_BITS, CRC_BITS, DELIM_BITS, END_BITS) + 1);
    localparam int GRP_W = $clog2(WORDS_PER_CRC + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] wc_q, wc_d, exp_q, exp_d, wc_inc;
    logic [GRP_W-1:0] grp_q, grp_d, grp_inc;
    // CRC sub-phase: 0 counting bits, 1 crc_read high, 2 crc_error valid
    logic [1:0]       ph_q, ph_d;
    logic             crc_read_q, crc_read_d;
    logic             ok_q, ok_d, err_q, err_d;
    logic [2:0]       code_q, code_d;
    logic             fin;
    logic [2:0]       fin_code;
    logic [CNT_W-1:0] term;
    logic             tdone, timeout, clr;

    assign wc_inc  = wc_q + 1'b1;
    assign grp_inc = grp_q + 1'b1;
    assign clr     = (state_d != state_q);

    always_comb begin
        case (state_q)
            DELIM:     term = CNT_W'(DELIM_BITS);
            CRC:       term = CNT_W'(CRC_BITS);
            END_DELIM: term = CNT_W'(END_BITS);
            default:   term = CNT_W'(WORD_BITS);
        endcase
    end

    mvb_bit_timer #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk_i     (clk_24M),
        .rst_i     (rst),
        .clr_i     (clr),
        .bit_tick_i(bit_tick),
        .term_i    (term),
        .done_o    (tdone),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        grp_d      = grp_q;
        exp_d      = exp_q;
        ph_d       = ph_q;
        crc_read_d = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        fin        = 1'b0;
        fin_code   = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = DELIM;
            end
            DONE: begin
                state_d = IDLE;
                wc_d    = '0;
                grp_d   = '0;
                ph_d    = '0;
            end
            default: begin
                // line faults beat the watchdog, which beats per-state checks
                if (signal_error || quality_error) begin
                    fin = 1'b1; fin_code = ERR_SIGNAL;
                end else if (timeout) begin
                    fin = 1'b1; fin_code = ERR_TIMEOUT;
                end else begin
                    case (state_q)
                        DELIM: if (tdone) begin
                            if (delimiter_error) begin
                                fin = 1'b1; fin_code = ERR_DELIM;
                            end else if (m_frame) begin
                                exp_d = LEN_W'(1); state_d = DATA;
                            end else if (s_frame) begin
                                if (frame_length != '0 && frame_length <= LEN_W'(MAX_WORDS)) begin
                                    exp_d = frame_length; state_d = DATA;
                                end else begin
                                    fin = 1'b1; fin_code = ERR_LENGTH;
                                end
                            end else begin
                                fin = 1'b1; fin_code = ERR_DELIM;
                            end
                        end
                        DATA: if (tdone) begin
                            wc_d  = wc_inc;
                            grp_d = grp_inc;
                            if (grp_inc == GRP_W'(WORDS_PER_CRC) || wc_inc == exp_q)
                                state_d = CRC;
                        end
                        CRC: begin
                            case (ph_q)
                                2'd0: if (tdone) begin
                                    ph_d = 2'd1; crc_read_d = 1'b1;
                                end
                                2'd1: ph_d = 2'd2;
                                default: begin
                                    ph_d  = 2'd0;
                                    grp_d = '0;
                                    if (crc_error) begin
                                        fin = 1'b1; fin_code = ERR_CRC;
                                    end else if (wc_q < exp_q) begin
                                        state_d = DATA;
                                    end else begin
                                        state_d = END_DELIM;
                                    end
                                end
                            endcase
                        end
                        END_DELIM: if (tdone) begin
                            fin = 1'b1;
                            fin_code = e_frame ? ERR_NONE : ERR_END;
                        end
                        default: ;
                    endcase
                end
                if (fin) begin
                    state_d    = DONE;
                    ph_d       = '0;
                    crc_read_d = 1'b0;
                    code_d     = fin_code;
                    ok_d       = (fin_code == ERR_NONE);
                    err_d      = (fin_code != ERR_NONE);
                end
            end
        endcase
    end

    always_ff @(posedge clk_24M) begin
        if (rst) begin
            state_q    <= IDLE;
            wc_q       <= '0;
            grp_q      <= '0;
            exp_q      <= '0;
            ph_q       <= '0;
            crc_read_q <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            grp_q      <= grp_d;
            exp_q      <= exp_d;
            ph_q       <= ph_d;
            crc_read_q <= crc_read_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    // level outputs are forced low while rst is held
    assign start_check_en     = !rst && (state_q == IDLE);
    assign delimiter_check_en = !rst && (state_q == DELIM || state_q == END_DELIM);
    assign deser_en           = !rst && (state_q == DATA || state_q == CRC);
    assign crc_check_en       = !rst && (state_q == DATA || state_q == CRC);
    assign deser_wait         = !rst && (state_q == CRC);
    assign frame_end          = !rst && (state_q == END_DELIM);
    assign crc_read           = crc_read_q;
    assign frame_ok           = ok_q;
    assign frame_err          = err_q;
    assign err_code           = code_q;
    assign word_count         = wc_q;

endmodule

// File: tb/tb_mvb_frame_seq_ctrl.sv
module tb_mvb_frame_seq_ctrl;

    logic       clk_24M = 1'b0;
    logic       rst = 1'b1;
    logic       bit_tick = 0, frame_start = 0, s_frame = 0, m_frame = 0, e_frame = 0;
    logic       delimiter_error = 0, crc_error = 0, signal_error = 0, quality_error = 0;
    logic [4:0] frame_length = '0;
    logic       start_check_en, delimiter_check_en, deser_en, deser_wait, crc_check_en;
    logic       crc_read, frame_end, frame_ok, frame_err;
    logic [2:0] err_code;
    logic [4:0] word_count;

    int total = 0, bad = 0;
    int n_crc = 0, n_ok = 0, n_err = 0, n_deser = 0;
    int b_crc, b_ok, b_err, b_deser, cnt;
    logic [4:0] wc_done = '0;

    mvb_frame_seq_ctrl dut (
        .clk_24M(clk_24M), .rst(rst), .bit_tick(bit_tick), .frame_start(frame_start),
        .s_frame(s_frame), .m_frame(m_frame), .e_frame(e_frame),
        .delimiter_error(delimiter_error), .crc_error(crc_error),
        .signal_error(signal_error), .quality_error(quality_error),
        .frame_length(frame_length), .start_check_en(start_check_en),
        .delimiter_check_en(delimiter_check_en), .deser_en(deser_en),
        .deser_wait(deser_wait), .crc_check_en(crc_check_en), .crc_read(crc_read),
        .frame_end(frame_end), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .word_count(word_count)
    );

    always #5 clk_24M = ~clk_24M;

    // pulse/level monitor, sampled on the inactive edge
    always @(negedge clk_24M) begin
        if (!rst) begin
            if (crc_read) n_crc++;
            if (deser_en) n_deser++;
            if (frame_ok) begin n_ok++; wc_done = word_count; end
            if (frame_err) begin n_err++; wc_done = word_count; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_24M); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bit_tick = 1'b1; step();
            bit_tick = 1'b0; step();
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1; step(); frame_start = 1'b0;
    endtask

    task automatic snap();
        b_crc = n_crc; b_ok = n_ok; b_err = n_err; b_deser = n_deser;
    endtask

    initial begin
        // reset
        repeat (3) step();
        chk("rst_outs", {start_check_en, delimiter_check_en, deser_en, deser_wait, crc_check_en,
                         crc_read, frame_end, frame_ok, frame_err, err_code, word_count}, 0);
        rst = 1'b0; step();
        chk("rst_release_start_en", start_check_en, 1);

        // master frame
        snap(); m_frame = 1'b1; start_frame();
        chk("m_delim_en", delimiter_check_en, 1);
        ticks(9);
        chk("m_data_en", {deser_en, deser_wait}, 2'b10);
        ticks(16);
        chk("m_crc_wait", deser_wait, 1);
        chk("m_wc1", word_count, 1);
        ticks(8); step();
        chk("m_frame_end", frame_end, 1);
        e_frame = 1'b1; ticks(3); e_frame = 1'b0; m_frame = 1'b0;
        chk("m_crc_reads", n_crc - b_crc, 1);
        chk("m_ok", {n_ok - b_ok, n_err - b_err}, {32'd1, 32'd0});
        chk("m_wc_done", wc_done, 1);
        chk("m_code", err_code, 0);
        chk("m_wc_clear", word_count, 0);

        // slave frame, 5 words -> groups 4 + 1
        snap(); s_frame = 1'b1; frame_length = 5'd5; start_frame();
        ticks(9);
        ticks(16); ticks(16);
        chk("s5_data_nowait", {deser_en, deser_wait}, 2'b10);
        ticks(16); ticks(16);
        chk("s5_grp_crc", {deser_wait, word_count}, {1'b1, 5'd4});
        ticks(8); step();
        chk("s5_back_data", {deser_en, deser_wait}, 2'b10);
        chk("s5_crc1", n_crc - b_crc, 1);
        ticks(16);
        chk("s5_short_crc", {deser_wait, word_count}, {1'b1, 5'd5});
        ticks(8); step();
        chk("s5_end", frame_end, 1);
        e_frame = 1'b1; ticks(3); e_frame = 1'b0;
        chk("s5_crc2", n_crc - b_crc, 2);
        chk("s5_ok", n_ok - b_ok, 1);
        chk("s5_wc_done", wc_done, 5);

        // illegal lengths
        for (int k = 0; k < 2; k++) begin
            snap(); frame_length = (k == 0) ? 5'd0 : 5'd17; start_frame();
            ticks(9);
            chk("len_err", n_err - b_err, 1);
            chk("len_code", err_code, 2);
            chk("len_no_data", n_deser - b_deser, 0);
        end

        // CRC error after first group of an 8-word frame
        snap(); frame_length = 5'd8; start_frame();
        ticks(9); ticks(16 * 4); ticks(8);
        crc_error = 1'b1; step(); crc_error = 1'b0;
        chk("crc_err_pulse", frame_err, 1);
        chk("crc_code", err_code, 4);
        chk("crc_wc", word_count, 4);
        step(); s_frame = 1'b0;
        chk("crc_reads", n_crc - b_crc, 1);

        // bit-gap timeout in DATA
        snap(); m_frame = 1'b1; start_frame();
        ticks(9); ticks(5);
        cnt = 0;
        while (!frame_err && cnt < 200) begin step(); cnt++; end
        chk("to_cycles", cnt, 63);
        chk("to_code", err_code, 6);
        step();

        // signal_error on the very cycle the timeout would fire
        start_frame(); ticks(9); ticks(5);
        repeat (62) step();
        signal_error = 1'b1; step(); signal_error = 1'b0;
        chk("sig_pulse", frame_err, 1);
        chk("sig_code", err_code, 3);
        step();

        // second frame_start inside DATA, then reset mid-frame
        snap(); start_frame(); ticks(9); ticks(5);
        start_frame();
        chk("fs_ignored", {delimiter_check_en, deser_en}, 2'b01);
        ticks(11);
        chk("fs_word_kept", {deser_wait, word_count}, {1'b1, 5'd1});
        rst = 1'b1; step();
        chk("rst_mid_outs", {start_check_en, delimiter_check_en, deser_en, deser_wait, crc_check_en,
                             crc_read, frame_end, frame_ok, frame_err, err_code, word_count}, 0);
        rst = 1'b0; m_frame = 1'b0; step();
        chk("rst_mid_start_en", start_check_en, 1);
        repeat (3) step();
        chk("rst_mid_no_pulse", {n_ok - b_ok, n_err - b_err}, {32'd0, 32'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mvb_frame_seq_ctrl.md
Name: mvb_frame_seq_ctrl

Overview:
- Parametrised successor to the MVB receive-path decode controller.
- Sequences start-delimiter check, data deserialisation, per-group CRC check and end-delimiter check for one MVB frame.
- Runs on one clock, with bit_tick strobes in place of derived bit clocks. Adds a bit-gap timeout, frame-length range checking, a latched error code and per-frame done pulses.
- Sits between the Manchester front end / delimiter detector and the deserialiser / CRC checker.

Parameters:
- MAX_WORDS, 16, largest legal slave frame length in 16-bit words.
- LEN_W, 5, width of frame_length and word_count; must hold MAX_WORDS.
- WORD_BITS, 16, bits per data word.
- WORDS_PER_CRC, 4, data words covered by one CRC field.
- CRC_BITS, 8, bits per CRC field.
- DELIM_BITS, 9, bit times of the start delimiter after frame_start.
- END_BITS, 3, bit times of the end delimiter.
- TIMEOUT_CYC, 64, clk_24M cycles allowed between bit_tick pulses while busy.

Ports:
- clk_24M  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- bit_tick  in  1  one-cycle strobe, one per received bit time.
- frame_start  in  1  start bit detected.
- s_frame  in  1  slave delimiter recognised.
- m_frame  in  1  master delimiter recognised.
- e_frame  in  1  end delimiter recognised.
- delimiter_error  in  1  delimiter mismatch.
- crc_error  in  1  CRC result; valid the cycle after crc_read.
- signal_error  in  1  line code violation.
- quality_error  in  1  signal quality fault.
- frame_length  in  LEN_W  slave frame length in words; sampled with s_frame.
- start_check_en  out  1  high in IDLE.
- delimiter_check_en  out  1  high in DELIM and END_DELIM.
- deser_en  out  1  high in DATA and CRC.
- deser_wait  out  1  high in CRC.
- crc_check_en  out  1  high in DATA and CRC.
- crc_read  out  1  one-cycle pulse at the end of each CRC field.
- frame_end  out  1  high in END_DELIM.
- frame_ok  out  1  one-cycle pulse: frame accepted.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  3  cause of last rejection; holds until the next frame_ok/frame_err.
- word_count  out  LEN_W  data words received in the current frame.

Behaviour:
- Reset (rst=1 at a clk_24M edge):
  - state=IDLE; all counters 0; err_code=0; word_count=0.
  - All outputs 0 while rst is high; start_check_en=1 from the first cycle after rst falls.
  - rst mid-frame aborts the frame with no frame_ok/frame_err pulse.
- Outputs:
  - Level outputs are decoded from the registered state.
  - crc_read, frame_ok and frame_err are registered pulses.
- Counters:
  - bit_cnt counts bit_tick only and clears on every state change.
  - grp_cnt counts words since the last CRC field and wraps to 0 after each CRC field.
- IDLE:
  - frame_start=1 → DELIM next cycle.
  - frame_start outside IDLE is ignored.
- DELIM:
  - On the bit_tick that completes DELIM_BITS, sample the inputs (first match wins):
    - delimiter_error=1 → err 1.
    - m_frame=1 → exp_words=1, go to DATA.
    - s_frame=1 with frame_length in 1..MAX_WORDS → exp_words=frame_length, go to DATA.
    - s_frame=1 with frame_length=0 or >MAX_WORDS → err 2.
    - Neither s_frame nor m_frame → err 1.
- DATA:
  - The bit_tick that completes WORD_BITS increments word_count and grp_cnt.
  - If grp_cnt reaches WORDS_PER_CRC, or word_count equals exp_words → CRC.
  - The final group may be short (e.g. 5 words = 4 + 1).
- CRC:
  - The bit_tick that completes CRC_BITS sets crc_read=1 in the following cycle.
  - In the cycle after crc_read, sample crc_error:
    - crc_error=1 → err 4.
    - word_count<exp_words → DATA.
    - Otherwise → END_DELIM.
- END_DELIM:
  - On the bit_tick that completes END_BITS: e_frame=1 → DONE ok; otherwise err 5.
- DONE:
  - Lasts one cycle; frame_ok or frame_err pulses here, then → IDLE.
  - word_count clears on entry to IDLE.
- Error priority, in any state except IDLE and DONE:
  - signal_error or quality_error → err 3 immediately (DONE next cycle).
  - Else no bit_tick for TIMEOUT_CYC consecutive cycles → err 6.
  - Else the state-specific checks above.
- err_code values: 0 none, 1 delimiter, 2 length, 3 signal/quality, 4 CRC, 5 end delimiter, 6 timeout.
- err_code is written in DONE (0 on success).
- Timeout counter: saturating, cleared by bit_tick and on state entry.

Decomposition:
- Package mvb_pkg holds:
  - State enum: IDLE, DELIM, DATA, CRC, END_DELIM, DONE.
  - ERR_* code constants.
  - Default bit-count constants.
- Sub-module mvb_bit_timer: bit_tick counter with terminal-count compare, plus the watchdog timeout counter, reused by all states.

Test Plan:
- Master frame: frame_start, 9 ticks with m_frame, 16 + 8 ticks, crc_error=0, 3 ticks with e_frame → one crc_read; frame_ok; word_count=1 before clear; err_code=0.
- Slave frame, frame_length=5: crc_read after word 4 and after word 5; deser_wait high only during the CRC fields; frame_ok.
- Slave frame, frame_length=0, and frame_length=17 → frame_err, err_code=2, no DATA entry.
- crc_error=1 after the first crc_read in an 8-word frame → frame_err, err_code=4; word_count=4 at DONE.
- bit_tick stopped for 64 cycles in DATA → frame_err, err_code=6. signal_error asserted in the same cycle as the timeout → err_code=3.
- rst pulsed mid-DATA → IDLE, no pulse, all outputs 0, start_check_en=1 after release. A second frame_start inside DATA is ignored.
